// File: rtl/spi_req_arbiter.sv
// spi_req_arbiter: shares one spi_master among NUM_REQ requesters, timing each transfer in sys_clk cycles.
// Round-robin by default; define SPI_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority.
module spi_req_arbiter #(
   parameter int NUM_REQ       = 4,
   parameter int REG_WIDTH     = 32,
   parameter int COUNTER_WIDTH = $clog2(REG_WIDTH),
   parameter int GAP_CYCLES    = 2
) (
   input  logic                                 sys_clk,
   input  logic                                 rst,
   input  logic [NUM_REQ-1:0]                   req_valid,
   input  logic [NUM_REQ*REG_WIDTH-1:0]         req_data,
   input  logic [NUM_REQ*(COUNTER_WIDTH+1)-1:0] req_size,
   input  logic [NUM_REQ-1:0]                   req_cpol,
   input  logic [NUM_REQ-1:0]                   req_cpha,
   output logic [NUM_REQ-1:0]                   req_ack,
   output logic [NUM_REQ-1:0]                   req_done,
   output logic                                 busy,
   output logic                                 spi_rstn,
   output logic                                 spi_start,
   output logic [REG_WIDTH-1:0]                 spi_data,
   output logic [COUNTER_WIDTH:0]               spi_size,
   output logic                                 spi_cpol,
   output logic                                 spi_cpha
);
   localparam int SW = COUNTER_WIDTH + 1;
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int GW = $clog2(GAP_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, GRANT, START, SHIFT, DONE, GAP} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] win_q, win_d, pick;
   logic found;
   logic [SW-1:0] bit_cnt_q, bit_cnt_d;
   logic [GW-1:0] gap_cnt_q, gap_cnt_d;
   logic [REG_WIDTH-1:0] spi_data_q, spi_data_d, pick_data;
   logic [SW-1:0] spi_size_q, spi_size_d, pick_size;
   logic spi_cpol_q, spi_cpol_d, spi_cpha_q, spi_cpha_d;
   logic spi_rstn_q, spi_rstn_d, spi_start_q, spi_start_d, busy_q, busy_d;
   logic [NUM_REQ-1:0] req_ack_q, req_ack_d, req_done_q, req_done_d;

   assign pick_data = req_data[int'(pick)*REG_WIDTH +: REG_WIDTH];
   assign pick_size = req_size[int'(pick)*SW +: SW];

`ifdef SPI_ARB_FIXED_PRIO_EN
   always_comb begin
      pick = '0;
      found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (req_valid[i]) begin
            pick = IW'(i);
            found = 1'b1;
         end
   end
`else
   logic [IW-1:0] rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] rot;
   // rot[i] is the request i places after rr_ptr, so the lowest set bit wins
   always_comb begin
      rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr_q);
      pick = '0;
      found = 1'b0;
      for (int i = NUM_REQ - 1; i >= 0; i--)
         if (rot[i]) begin
            pick = IW'((int'(rr_ptr_q) + i) % NUM_REQ);
            found = 1'b1;
         end
      rr_ptr_d = (state_q == IDLE && found) ? IW'((int'(pick) + 1) % NUM_REQ) : rr_ptr_q;
   end

   always_ff @(posedge sys_clk or posedge rst)
      if (rst) rr_ptr_q <= '0;
      else rr_ptr_q <= rr_ptr_d;
`endif

   always_comb begin
      state_d = state_q;
      win_d = win_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      spi_data_d = spi_data_q;
      spi_size_d = spi_size_q;
      spi_cpol_d = spi_cpol_q;
      spi_cpha_d = spi_cpha_q;
      case (state_q)
         IDLE: if (found) begin
            state_d = GRANT;
            win_d = pick;
            spi_data_d = pick_data;
            spi_size_d = (pick_size > SW'(REG_WIDTH)) ? SW'(REG_WIDTH) : pick_size;
            spi_cpol_d = req_cpol[pick];
            spi_cpha_d = req_cpha[pick];
         end
         GRANT: state_d = (spi_size_q == '0) ? DONE : START;
         START: begin
            state_d = SHIFT;
            bit_cnt_d = spi_size_q;
         end
         SHIFT: begin
            bit_cnt_d = bit_cnt_q - SW'(1);
            state_d = (bit_cnt_q == SW'(1)) ? DONE : SHIFT;
         end
         DONE: begin
            gap_cnt_d = GW'(GAP_CYCLES - 1);
            state_d = (GAP_CYCLES > 1) ? GAP : IDLE;
         end
         GAP: begin
            gap_cnt_d = gap_cnt_q - GW'(1);
            state_d = (gap_cnt_q == GW'(1)) ? IDLE : GAP;
         end
         default: state_d = IDLE;
      endcase
      // outputs are registered copies of what the next state implies
      spi_rstn_d = (state_d == START) || (state_d == SHIFT);
      spi_start_d = (state_d == START);
      busy_d = (state_d != IDLE);
      req_ack_d = (state_d == GRANT) ? NUM_REQ'(1) << win_d : '0;
      req_done_d = (state_d == DONE) ? NUM_REQ'(1) << win_d : '0;
   end

   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         win_q <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         spi_data_q <= '0;
         spi_size_q <= '0;
         spi_cpol_q <= 1'b0;
         spi_cpha_q <= 1'b0;
         spi_rstn_q <= 1'b0;
         spi_start_q <= 1'b0;
         busy_q <= 1'b0;
         req_ack_q <= '0;
         req_done_q <= '0;
      end else begin
         state_q <= state_d;
         win_q <= win_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         spi_data_q <= spi_data_d;
         spi_size_q <= spi_size_d;
         spi_cpol_q <= spi_cpol_d;
         spi_cpha_q <= spi_cpha_d;
         spi_rstn_q <= spi_rstn_d;
         spi_start_q <= spi_start_d;
         busy_q <= busy_d;
         req_ack_q <= req_ack_d;
         req_done_q <= req_done_d;
      end

   assign req_ack = req_ack_q;
   assign req_done = req_done_q;
   assign busy = busy_q;
   assign spi_rstn = spi_rstn_q;
   assign spi_start = spi_start_q;
   assign spi_data = spi_data_q;
   assign spi_size = spi_size_q;
   assign spi_cpol = spi_cpol_q;
   assign spi_cpha = spi_cpha_q;
endmodule

// File: tb/tb_spi_req_arbiter.sv
// tb_spi_req_arbiter: directed and randomized checks of spi_req_arbiter against a transaction-level model.
module tb_spi_req_arbiter;
   localparam int GAP = 2;
   logic sys_clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] req_valid = '0;
   logic [127:0] req_data = '0;
   logic [23:0] req_size = '0;
   logic [3:0] req_cpol = '0, req_cpha = '0;
   logic [3:0] req_ack, req_done;
   logic busy, spi_rstn, spi_start, spi_cpol, spi_cpha;
   logic [31:0] spi_data;
   logic [5:0] spi_size;
   int n_tests = 0, n_fail = 0, model_ptr = 0;
   logic [31:0] f_data[4];
   int f_size[4];
   logic f_pol[4], f_pha[4];

   spi_req_arbiter dut (
      .sys_clk(sys_clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
      .req_size(req_size), .req_cpol(req_cpol), .req_cpha(req_cpha), .req_ack(req_ack),
      .req_done(req_done), .busy(busy), .spi_rstn(spi_rstn), .spi_start(spi_start),
      .spi_data(spi_data), .spi_size(spi_size), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha)
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [31:0] d, input int sz, input logic pol, input logic pha);
      f_data[i] = d;
      f_size[i] = sz;
      f_pol[i] = pol;
      f_pha[i] = pha;
      req_data[i*32 +: 32] = d;
      req_size[i*6 +: 6] = 6'(sz);
      req_cpol[i] = pol;
      req_cpha[i] = pha;
   endtask

   // Arbitration rule: scan from the pointer, wrap, first valid wins, pointer moves past it
   task automatic model_grant(input logic [3:0] mask, output int w);
      int j;
      w = -1;
`ifdef SPI_ARB_FIXED_PRIO_EN
      for (int i = 0; i < 4; i++) if (w < 0 && mask[i]) w = i;
`else
      for (int k = 0; k < 4; k++) begin
         j = (model_ptr + k) % 4;
         if (w < 0 && mask[j[1:0]]) w = j;
      end
      if (w >= 0) model_ptr = (w + 1) % 4;
`endif
   endtask

   task automatic reset_dut();
      req_valid = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_ptr = 0;
   endtask

   // Expects one full transaction for requester w, starting from an IDLE cycle
   task automatic txn(input int w, input logic [31:0] d, input int sz, input logic pol, input logic pha,
                      input bit drop, input int poke);
      int waited, hi, g, bad, n;
      n = (sz > 32) ? 32 : sz;
      waited = 0;
      while (req_ack === 4'b0 && waited < 100) begin
         tick();
         waited++;
      end
      check("ack_latency", waited, 1);
      check("ack", req_ack, 1 << w);
      if (drop) req_valid = req_valid & ~(4'(1) << w);
      check("spi_data", spi_data, d);
      check("spi_size", spi_size, n);
      check("spi_cpol", spi_cpol, pol);
      check("spi_cpha", spi_cpha, pha);
      check("rstn_in_grant", spi_rstn, 0);
      tick();
      check("start", spi_start, n > 0);
      hi = 0;
      bad = 0;
      while (spi_rstn === 1'b1 && hi < 100) begin
         if (spi_data !== d || spi_size !== 6'(n) || spi_cpol !== pol || spi_cpha !== pha ||
             spi_start !== (hi == 0) || req_done !== 4'b0 || busy !== 1'b1) bad++;
         if (hi == 3 && poke >= 0) req_valid = req_valid | (4'(1) << poke);
         if (hi == 4 && poke >= 0) req_valid = req_valid & ~(4'(1) << poke);
         hi++;
         tick();
      end
      check("rstn_high_cycles", hi, (n == 0) ? 0 : n + 1);
      check("window_stable", bad, 0);
      check("done", req_done, 1 << w);
      g = 0;
      bad = 0;
      while (busy === 1'b1 && g < 100) begin
         if (spi_rstn !== 1'b0 || spi_start !== 1'b0 || req_ack !== 4'b0) bad++;
         g++;
         tick();
      end
      check("gap_cycles", g, GAP);
      check("gap_rstn_low", bad, 0);
   endtask

   initial begin
      int w;
      logic [3:0] mask, ack_or;
      #3;
      check("rst_rstn", spi_rstn, 0);
      check("rst_start", spi_start, 0);
      check("rst_data", spi_data, 0);
      check("rst_size", spi_size, 0);
      check("rst_cpol", spi_cpol, 0);
      check("rst_cpha", spi_cpha, 0);
      check("rst_ack", req_ack, 0);
      check("rst_done", req_done, 0);
      check("rst_busy", busy, 0);
      reset_dut();

      set_req(0, 32'hA5A5_0F0F, 32, 1'b0, 1'b0);
      req_valid = 4'b0001;
      model_grant(req_valid, w);
      txn(w, f_data[w], f_size[w], f_pol[w], f_pha[w], 1, -1);

      set_req(2, 32'h8000_0001, 32, 1'b1, 1'b1);
      req_valid = 4'b0100;
      model_grant(req_valid, w);
      txn(w, f_data[w], f_size[w], f_pol[w], f_pha[w], 1, -1);

      set_req(3, 32'h1357_9BDF, 0, 1'b1, 1'b0);
      req_valid = 4'b1000;
      model_grant(req_valid, w);
      txn(w, f_data[w], f_size[w], f_pol[w], f_pha[w], 1, -1);

      set_req(1, 32'hDEAD_BEEF, 40, 1'b0, 1'b1);
      req_valid = 4'b0010;
      model_grant(req_valid, w);
      txn(w, f_data[w], f_size[w], f_pol[w], f_pha[w], 1, -1);

      set_req(0, 32'h0F0F_1234, 12, 1'b1, 1'b0);
      req_valid = 4'b0001;
      model_grant(req_valid, w);
      txn(w, f_data[w], f_size[w], f_pol[w], f_pha[w], 1, 1);
      ack_or = '0;
      repeat (10) begin
         ack_or = ack_or | req_ack;
         tick();
      end
      check("withdrawn_no_ack", ack_or, 0);
      check("withdrawn_idle", busy, 0);

      set_req(2, 32'h1234_5678, 32, 1'b0, 1'b1);
      set_req(1, 32'hCAFE_F00D, 8, 1'b1, 1'b0);
      set_req(3, 32'h0000_00FF, 8, 1'b0, 1'b0);
      req_valid = 4'b0100;
      model_grant(req_valid, w);
      tick();
      check("abort_ack", req_ack, 1 << w);
      req_valid = 4'b1010;
      tick();
      check("abort_start", spi_start, 1);
      repeat (10) tick();
      check("abort_shift_rstn", spi_rstn, 1);
      rst = 1'b1;
      #1;
      check("abort_rstn", spi_rstn, 0);
      check("abort_busy", busy, 0);
      check("abort_pulses", {req_ack, req_done, spi_start}, 0);
      model_ptr = 0;
      tick();
      check("abort_no_done", req_done, 0);
      rst = 1'b0;
      model_grant(req_valid, w);
      txn(w, f_data[w], f_size[w], f_pol[w], f_pha[w], 1, -1);
      req_valid = '0;

      reset_dut();
      for (int i = 0; i < 4; i++) set_req(i, 32'h1111_1111 * (i + 1), 8, i[0], i[1]);
      req_valid = 4'b1111;
      repeat (5) begin
         model_grant(req_valid, w);
         txn(w, f_data[w], f_size[w], f_pol[w], f_pha[w], 0, -1);
      end
      req_valid = '0;

      for (int it = 0; it < 20; it++) begin
         for (int i = 0; i < 4; i++)
            set_req(i, $urandom, int'($urandom_range(0, 40)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         mask = 4'($urandom_range(1, 15));
         req_valid = mask;
         model_grant(mask, w);
         txn(w, f_data[w], f_size[w], f_pol[w], f_pha[w], 1, -1);
      end
      req_valid = '0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
